// File: rtl/task_2_pkg.sv
`default_nettype none
// ============================================================================
// Package  : task_2_pkg
// Brief    : Shared types and constants for the task_2 transmit end.
// Revision : 1.0 - initial release
// ============================================================================
package task_2_pkg;

  // Default byte width of the core-to-stream datapath
  localparam int TASK_2_DATA_W = 8;

  // Frame handling phases of the output block
  typedef enum logic [1:0] {
    s_IDLE    = 2'd0,
    s_COLLECT = 2'd1,
    s_SEND    = 2'd2,
    s_DONE    = 2'd3
  } task_2_output_enum;

endpackage
`default_nettype wire

// File: rtl/task_2_output_fifo.sv
`default_nettype none
// ============================================================================
// Module   : task_2_output_fifo
// Brief    : Synchronous first-word-fall-through FIFO. q always shows the
//            oldest stored word; rdreq pops it. Async active-low clear empties
//            the FIFO without touching the storage array.
// Revision : 1.0 - initial release
// ============================================================================
module task_2_output_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              wrreq,
  input  logic              rdreq,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] q,
  output logic              empty,
  output logic              full
);

  localparam int              ADDR_W     = $clog2(DEPTH);
  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count;
  logic              do_wr;
  logic              do_rd;

  // Requests against a full/empty FIFO are ignored rather than corrupting it
  assign do_wr = wrreq && !full;
  assign do_rd = rdreq && !empty;

  // Storage array; contents only matter between valid pointers, so no reset
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= data;
    end
  end

  // Pointers wrap modulo DEPTH; count carries one extra bit to tell full from empty
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign q     = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == FULL_COUNT);

endmodule
`default_nettype wire

// File: rtl/task_2_output.sv
`default_nettype none
// ============================================================================
// Module   : task_2_output
// Brief    : Transmit end of the task_2 datapath. Buffers one frame of bytes
//            from the core, then replays it as a valid/ready stream with last
//            on the final beat, and pulses o_output_last once it has left.
// Config   : define TASK_2_OUTPUT_LEN_EN to add the o_frame_len output.
// Revision : 1.0 - initial release
// ============================================================================
module task_2_output
  import task_2_pkg::*;
#(
  parameter int DATA_W = TASK_2_DATA_W,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_enb,
  input  logic              i_frame_end,
  input  logic              i_tready,
  output logic [DATA_W-1:0] o_tdata,
  output logic              o_tvalid,
  output logic              o_tlast,
  output logic              o_output_last,
  output logic              o_busy,
  output logic              o_empty,
  output logic              o_full,
  output logic              o_overflow
`ifdef TASK_2_OUTPUT_LEN_EN
  ,
  output logic [ADDR_W:0]   o_frame_len
`endif
);

  localparam logic [ADDR_W:0] ONE_CNT = (ADDR_W+1)'(1);

  task_2_output_enum state;
  logic [ADDR_W:0]   cnt;
  logic              overflow;
  logic              fifo_empty;
  logic              fifo_full;
  logic [DATA_W-1:0] fifo_q;
  logic              collecting;
  logic              wr_en;
  logic              drop;
  logic              tvalid;
  logic              beat;
  logic              tlast;

  // Bytes are only accepted while building a frame and while there is room
  assign collecting = (state == s_IDLE) || (state == s_COLLECT);
  assign wr_en      = i_enb && collecting && !fifo_full;
  assign drop       = i_enb && !wr_en;

  // Stream side is decoded from registered state only, never from i_tready
  assign tvalid = (state == s_SEND) && !fifo_empty;
  assign beat   = tvalid && i_tready;
  assign tlast  = tvalid && (cnt == ONE_CNT);

  task_2_output_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk    (i_clk),
    .clr_n  (i_rst),
    .wrreq  (wr_en),
    .rdreq  (beat),
    .data   (i_data),
    .q      (fifo_q),
    .empty  (fifo_empty),
    .full   (fifo_full)
  );

  // Frame FSM: cnt counts stored bytes while collecting and remaining beats while sending
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state    <= s_IDLE;
      cnt      <= '0;
      overflow <= 1'b0;
    end else begin
      if (drop) begin
        overflow <= 1'b1;
      end
      case (state)
        s_IDLE: begin
          if (i_enb) begin
            cnt   <= ONE_CNT;
            state <= i_frame_end ? s_SEND : s_COLLECT;
          end
        end
        s_COLLECT: begin
          if (wr_en) begin
            cnt <= cnt + 1'b1;
          end
          // A dropped byte carrying the frame end still closes the frame
          if (i_enb && i_frame_end) begin
            state <= s_SEND;
          end
        end
        s_SEND: begin
          if (beat) begin
            cnt <= cnt - 1'b1;
            if (tlast) begin
              state <= s_DONE;
            end
          end
        end
        s_DONE: begin
          state <= s_IDLE;
        end
        default: begin
          state <= s_IDLE;
        end
      endcase
    end
  end

`ifdef TASK_2_OUTPUT_LEN_EN
  logic [ADDR_W:0] frame_len;

  // Capture the stored length on entry to send; clear when the next frame starts collecting
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      frame_len <= '0;
    end else begin
      case (state)
        s_IDLE: begin
          if (i_enb) begin
            frame_len <= i_frame_end ? ONE_CNT : '0;
          end
        end
        s_COLLECT: begin
          if (i_enb && i_frame_end) begin
            frame_len <= wr_en ? (cnt + 1'b1) : cnt;
          end
        end
        default: begin
          frame_len <= frame_len;
        end
      endcase
    end
  end

  assign o_frame_len = frame_len;
`endif

  // Data is forced to zero when no beat is offered so the bus is clean out of reset
  assign o_tdata       = tvalid ? fifo_q : '0;
  assign o_tvalid      = tvalid;
  assign o_tlast       = tlast;
  assign o_output_last = (state == s_DONE);
  assign o_busy        = (state != s_IDLE);
  assign o_empty       = fifo_empty;
  assign o_full        = fifo_full;
  assign o_overflow    = overflow;

endmodule
`default_nettype wire

// File: tb/tb_task_2_output.sv
`default_nettype none
// ============================================================================
// Module   : tb_task_2_output
// Brief    : Scoreboard bench for task_2_output. Frames are pushed to an
//            expected-beat queue as they are driven and popped as beats leave.
// Revision : 1.0 - initial release
// ============================================================================
module tb_task_2_output;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [DATA_W-1:0] data;
  logic              enb;
  logic              frame_end;
  logic              tready;
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tlast;
  logic              output_last;
  logic              busy;
  logic              empty;
  logic              full;
  logic              overflow;
`ifdef TASK_2_OUTPUT_LEN_EN
  logic [ADDR_W:0]   frame_len;
`endif

  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    ol_count = 0;
  int    beat_count = 0;
  int    beat_cyc[$];
  beat_t sb[$];
  bit    ovf_model = 1'b0;

  task_2_output #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst_n),
    .i_data        (data),
    .i_enb         (enb),
    .i_frame_end   (frame_end),
    .i_tready      (tready),
    .o_tdata       (tdata),
    .o_tvalid      (tvalid),
    .o_tlast       (tlast),
    .o_output_last (output_last),
    .o_busy        (busy),
    .o_empty       (empty),
    .o_full        (full),
    .o_overflow    (overflow)
`ifdef TASK_2_OUTPUT_LEN_EN
    ,
    .o_frame_len   (frame_len)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_tdata", tdata, 0);
    check("rst_tvalid", tvalid, 0);
    check("rst_tlast", tlast, 0);
    check("rst_output_last", output_last, 0);
    check("rst_busy", busy, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_overflow", overflow, 0);
  endtask

  // Output monitor: sampled on the falling edge, away from the active edge
  logic              ol_expect = 1'b0;
  logic              busy_low = 1'b0;
  logic              hold_pending = 1'b0;
  logic [DATA_W-1:0] held_data;
  logic              held_last;
  beat_t             exp_b;

  always @(negedge clk) begin
    if (!rst_n) begin
      ol_expect    = 1'b0;
      busy_low     = 1'b0;
      hold_pending = 1'b0;
    end else begin
      check("output_last", output_last, ol_expect);
      if (output_last) ol_count++;
      if (busy_low) check("busy_fall", busy, 0);
      busy_low = output_last;
      if (hold_pending) begin
        check("hold_valid", tvalid, 1);
        check("hold_data", tdata, held_data);
        check("hold_last", tlast, held_last);
      end
      hold_pending = tvalid && !tready;
      held_data    = tdata;
      held_last    = tlast;
      ol_expect    = 1'b0;
      if (tvalid && tready) begin
        if (sb.size() == 0) begin
          check("beat_unexpected", tvalid, 0);
        end else begin
          exp_b = sb.pop_front();
          check("beat_data", tdata, exp_b.data);
          check("beat_last", tlast, exp_b.last);
          ol_expect = exp_b.last;
          beat_count++;
          beat_cyc.push_back(cyc);
        end
      end
    end
  end

  // Drive one frame of n bytes and record what the DUT should store
  task automatic send_frame(input int n, input logic [DATA_W-1:0] base, input logic [DATA_W-1:0] step);
    int    stored = 0;
    beat_t b;
    for (int i = 0; i < n; i++) begin
      enb       = 1'b1;
      data      = base + DATA_W'(i) * step;
      frame_end = (i == n - 1);
      if (stored < DEPTH) begin
        sb.push_back(beat_t'{data, 1'b0});
        stored++;
      end else begin
        ovf_model = 1'b1;
      end
      if (i == n - 1) begin
        b      = sb.pop_back();
        b.last = 1'b1;
        sb.push_back(b);
      end
      @(posedge clk); #1;
      check("collect_full", full, (stored == DEPTH));
      check("collect_empty", empty, 0);
      check("collect_busy", busy, 1);
      check("collect_overflow", overflow, ovf_model);
    end
    enb       = 1'b0;
    frame_end = 1'b0;
`ifdef TASK_2_OUTPUT_LEN_EN
    check("frame_len", frame_len, stored);
`endif
  endtask

  // Wait for the frame to drain; toggle=1 applies the ready pattern 1,0,0,1
  task automatic wait_frame(input bit toggle);
    int         start = ol_count;
    logic [3:0] pat = 4'b1001;
    for (int k = 0; k < 4 * DEPTH + 100; k++) begin
      tready = toggle ? pat[k % 4] : 1'b1;
      @(posedge clk); #1;
      if (ol_count != start) break;
    end
    tready = 1'b1;
    check("frame_done", ol_count - start, 1);
    check("sb_drained", sb.size(), 0);
  endtask

  initial begin
    int start;
    int ol0;
    rst_n     = 1'b0;
    enb       = 1'b0;
    data      = '0;
    frame_end = 1'b0;
    tready    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 4-byte frame, always ready: back-to-back beats
    beat_cyc.delete();
    send_frame(4, 8'h11, 8'h11);
    wait_frame(1'b0);
    check("t1_beats", beat_cyc.size(), 4);
    if (beat_cyc.size() == 4) check("t1_spacing", beat_cyc[3] - beat_cyc[0], 3);

    // Same frame with back-pressure
    beat_cyc.delete();
    send_frame(4, 8'h11, 8'h11);
    wait_frame(1'b1);
    check("t2_beats", beat_cyc.size(), 4);

    // Single-byte frame straight from idle
    beat_cyc.delete();
    send_frame(1, 8'hA5, 8'h00);
    wait_frame(1'b0);
    check("t3_beats", beat_cyc.size(), 1);

    // Byte arriving while sending is dropped and flagged
    check("t4_ovf_before", overflow, 0);
    beat_cyc.delete();
    send_frame(4, 8'h51, 8'h01);
    enb  = 1'b1;
    data = 8'hEE;
    ovf_model = 1'b1;
    @(posedge clk); #1;
    enb = 1'b0;
    check("t4_ovf_set", overflow, 1);
    wait_frame(1'b0);
    check("t4_beats", beat_cyc.size(), 4);
    check("t4_ovf_sticky", overflow, 1);

    // Reset after two of four beats
    send_frame(4, 8'h61, 8'h01);
    start  = beat_count;
    tready = 1'b1;
    for (int k = 0; k < 50; k++) begin
      if (beat_count >= start + 2) break;
      @(posedge clk); #1;
    end
    check("t5_two_beats", beat_count - start, 2);
    rst_n  = 1'b0;
    tready = 1'b0;
    sb.delete();
    ovf_model = 1'b0;
    #1;
    check_reset_outputs();
    ol0 = ol_count;
    @(posedge clk); #1;
    rst_n  = 1'b1;
    tready = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      check("t5_idle_valid", tvalid, 0);
    end
    check("t5_no_output_last", ol_count, ol0);
    beat_cyc.delete();
    send_frame(3, 8'h30, 8'h01);
    wait_frame(1'b0);
    check("t5_next_beats", beat_cyc.size(), 3);

    // Overlong frame: DEPTH stored, two dropped, frame end on a dropped byte
    beat_cyc.delete();
    send_frame(DEPTH + 2, 8'h80, 8'h01);
    wait_frame(1'b0);
    check("t6_beats", beat_cyc.size(), DEPTH);
    check("t6_overflow", overflow, 1);
    check("t6_empty", empty, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
